// File: rtl/lazy_seq_commit_buffer.sv
// Commit buffer behind the lazy summary pipeline: owns the job head pointer, filters stale summaries,
// and queues committed sequences for the encoder. Define LAZY_COMMIT_STATS_EN to add statistics counters.
module lazy_seq_commit_buffer #(
    parameter int FIFO_DEPTH      = 8,
    parameter int AFULL_MARGIN    = 4,
    parameter int JOB_LEN_LOG2    = 8,
    parameter int SEQ_LL_BITS     = 16,
    parameter int SEQ_ML_BITS     = 16,
    parameter int SEQ_OFFSET_BITS = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_summary_done,
    input  logic [JOB_LEN_LOG2-1:0]    i_seq_head_ptr,
    input  logic [SEQ_LL_BITS-1:0]     i_summary_ll,
    input  logic [SEQ_ML_BITS-1:0]     i_summary_ml,
    input  logic [SEQ_OFFSET_BITS-1:0] i_summary_offset,
    input  logic                       i_summary_delim,
    input  logic                       i_summary_eoj,
    input  logic [SEQ_ML_BITS-1:0]     i_summary_overlap_len,
    input  logic                       i_move_to_next_job,
    input  logic [JOB_LEN_LOG2-1:0]    i_move_forward,
    output logic [JOB_LEN_LOG2-1:0]    o_head_ptr,
    output logic                       o_head_update,
    output logic                       o_job_advance,
    output logic                       o_stall,
    output logic                       o_seq_valid,
    input  logic                       i_seq_ready,
    output logic [SEQ_LL_BITS-1:0]     o_seq_ll,
    output logic [SEQ_ML_BITS-1:0]     o_seq_ml,
    output logic [SEQ_OFFSET_BITS-1:0] o_seq_offset,
    output logic                       o_seq_eoj,
    output logic                       o_seq_delim,
    output logic [SEQ_ML_BITS-1:0]     o_seq_overlap_len,
    output logic                       o_overflow
`ifdef LAZY_COMMIT_STATS_EN
    ,
    output logic [31:0]                o_stat_accepted,
    output logic [31:0]                o_stat_dropped,
    output logic [31:0]                o_stat_lit_bytes
`endif
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = SEQ_LL_BITS + 2 * SEQ_ML_BITS + SEQ_OFFSET_BITS + 2;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN_JOB} state_t;

    state_t                  state_reg, state_next;
    logic [JOB_LEN_LOG2-1:0] head_ptr_reg;
    logic                    head_update_reg, job_advance_reg;
    logic                    push_pending_reg;
    logic [ENTRY_W-1:0]      push_data_reg;
    logic [ENTRY_W-1:0]      mem [FIFO_DEPTH];
    logic [ENTRY_W-1:0]      out_data_reg, out_next;
    logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]        count_reg, count_next;
    logic                    valid_reg, overflow_reg, stall_reg, stall_next;
    logic                    accept, pop, full, push_en;

    assign accept      = i_summary_done && (i_seq_head_ptr == head_ptr_reg);
    assign pop         = valid_reg && i_seq_ready;
    assign full        = (count_reg == CNT_W'(FIFO_DEPTH));
    // A full FIFO still takes the push when the head is leaving in the same cycle.
    assign push_en     = push_pending_reg && (!full || pop);
    assign count_next  = count_reg + CNT_W'(push_en) - CNT_W'(pop);
    assign rd_ptr_next = rd_ptr_reg + PTR_W'(pop);
    // Bypass the array when the word being written is the one that becomes the new head.
    assign out_next    = (push_en && (wr_ptr_reg == rd_ptr_next)) ? push_data_reg : mem[rd_ptr_next];
    assign stall_next  = ((FIFO_DEPTH - int'(count_next)) <= AFULL_MARGIN) || (state_next == DRAIN_JOB);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (accept) state_next = i_summary_eoj ? DRAIN_JOB : RUN;
            RUN:       if (accept && i_summary_eoj) state_next = DRAIN_JOB;
            DRAIN_JOB: begin
                if (accept && i_summary_eoj)
                    state_next = DRAIN_JOB;
                else if (pop && o_seq_eoj)
                    state_next = o_seq_delim ? IDLE : RUN;
            end
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            head_ptr_reg     <= '0;
            head_update_reg  <= 1'b0;
            job_advance_reg  <= 1'b0;
            push_pending_reg <= 1'b0;
            push_data_reg    <= '0;
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            count_reg        <= '0;
            valid_reg        <= 1'b0;
            overflow_reg     <= 1'b0;
            stall_reg        <= 1'b0;
        end else begin
            state_reg        <= state_next;
            head_update_reg  <= accept;
            job_advance_reg  <= accept && i_move_to_next_job;
            push_pending_reg <= accept;
            if (accept) begin
                head_ptr_reg  <= i_move_to_next_job ? i_summary_overlap_len[JOB_LEN_LOG2-1:0]
                                                    : head_ptr_reg + i_move_forward;
                push_data_reg <= {i_summary_ll, i_summary_ml, i_summary_offset,
                                  i_summary_eoj, i_summary_delim, i_summary_overlap_len};
            end
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(push_en);
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            valid_reg  <= (count_next != '0);
            stall_reg  <= stall_next;
            if (push_pending_reg && full && !pop)
                overflow_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en)
            mem[wr_ptr_reg] <= push_data_reg;
        out_data_reg <= out_next;
    end

    assign o_head_ptr    = head_ptr_reg;
    assign o_head_update = head_update_reg;
    assign o_job_advance = job_advance_reg;
    assign o_stall       = stall_reg;
    assign o_seq_valid   = valid_reg;
    assign o_overflow    = overflow_reg;
    assign {o_seq_ll, o_seq_ml, o_seq_offset, o_seq_eoj, o_seq_delim, o_seq_overlap_len} = out_data_reg;

`ifdef LAZY_COMMIT_STATS_EN
    logic [31:0] stat_accepted_reg, stat_dropped_reg, stat_lit_bytes_reg;
    logic [32:0] lit_sum;

    assign lit_sum = {1'b0, stat_lit_bytes_reg} + 33'(i_summary_ll);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_accepted_reg  <= '0;
            stat_dropped_reg   <= '0;
            stat_lit_bytes_reg <= '0;
        end else begin
            if (accept) begin
                if (stat_accepted_reg != '1)
                    stat_accepted_reg <= stat_accepted_reg + 32'd1;
                stat_lit_bytes_reg <= lit_sum[32] ? '1 : lit_sum[31:0];
            end else if (i_summary_done && stat_dropped_reg != '1) begin
                stat_dropped_reg <= stat_dropped_reg + 32'd1;
            end
        end
    end

    assign o_stat_accepted  = stat_accepted_reg;
    assign o_stat_dropped   = stat_dropped_reg;
    assign o_stat_lit_bytes = stat_lit_bytes_reg;
`endif

endmodule

// File: doc/lazy_seq_commit_buffer.md
Name: lazy_seq_commit_buffer

Overview:
- Sits directly downstream of the lazy summary pipeline. Consumes its per-window summary pulses and keeps the authoritative sequence head pointer for the current job.
- Discards stale or speculative summaries. Buffers committed sequences in a FIFO with a valid/ready interface toward the sequence encoder.
- Upstream has no backpressure input, so this block supplies an early stall signal to the window issuer.

Parameters:
FIFO_DEPTH, 8, sequence FIFO entries (power of two, >=4)
AFULL_MARGIN, 4, free-entry count at or below which o_stall asserts; must be >= upstream pipeline depth (4)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_summary_done  in  1  summary valid pulse
i_seq_head_ptr  in  JOB_LEN_LOG2  head pointer the summary was computed for
i_summary_ll  in  SEQ_LL_BITS  literal length
i_summary_ml  in  SEQ_ML_BITS  match length
i_summary_offset  in  SEQ_OFFSET_BITS  match offset
i_summary_delim  in  1  job is last of block
i_summary_eoj  in  1  sequence ends job
i_summary_overlap_len  in  SEQ_ML_BITS  bytes the match runs into next job
i_move_to_next_job  in  1  advance to next job
i_move_forward  in  JOB_LEN_LOG2  head advance within job
o_head_ptr  out  JOB_LEN_LOG2  committed head pointer for the next window issue
o_head_update  out  1  one-cycle pulse when o_head_ptr changes or a job advances
o_job_advance  out  1  one-cycle pulse: current job finished
o_stall  out  1  upstream must not issue new windows
o_seq_valid  out  1  FIFO head valid
i_seq_ready  in  1  consumer accepts
o_seq_ll  out  SEQ_LL_BITS
o_seq_ml  out  SEQ_ML_BITS
o_seq_offset  out  SEQ_OFFSET_BITS
o_seq_eoj  out  1
o_seq_delim  out  1
o_seq_overlap_len  out  SEQ_ML_BITS
o_overflow  out  1  sticky: push attempted while full

Behaviour:
- Reset (async assert, sync release): head_ptr=0, FIFO count=0, all pulses=0, o_seq_valid=0, o_overflow=0, o_stall=0. Reset mid-traffic discards FIFO contents.
- Accept rule: summary accepted iff i_summary_done && i_seq_head_ptr==head_ptr. Otherwise it is dropped silently (stale speculation); no state changes.
- On accept, head update in the next cycle:
  - i_move_to_next_job=1: head_ptr <= i_summary_overlap_len[JOB_LEN_LOG2-1:0]; o_job_advance=1.
  - Otherwise: head_ptr <= head_ptr + i_move_forward, mod JOB_LEN (wrap ignored; upstream guarantees no wrap when not eoj).
  - o_head_update=1 in both cases.
- On accept, push {ll, ml, offset, eoj, delim, overlap_len} into the FIFO.
  - Push happens even when ll=0 and ml=0 (eoj marker).
- FIFO behaviour:
  - Registered output, first-word fall-through: a push into an empty FIFO gives o_seq_valid=1 in the following cycle.
  - Pop occurs when o_seq_valid && i_seq_ready. Output fields are stable while valid && !ready.
  - Push while count==FIFO_DEPTH with a pop in the same cycle is legal and accepted.
  - Push while full with no pop: entry dropped, o_overflow set (sticky until reset), head still updates.
  - Pointers wrap modulo FIFO_DEPTH; count is FIFO_DEPTH_LOG2+1 bits.
- o_stall is registered: 1 when (FIFO_DEPTH - count_next) <= AFULL_MARGIN.
- State: IDLE/RUN/DRAIN_JOB.
  - Accepted eoj summary moves RUN->DRAIN_JOB. While in DRAIN_JOB, o_stall is forced to 1.
  - Return to RUN when the eoj entry pops. If that entry also has delim, go to IDLE.
  - A summary matching head_ptr in IDLE moves to RUN.

Optional Feature:
LAZY_COMMIT_STATS_EN:
- Defined: adds outputs o_stat_accepted[31:0], o_stat_dropped[31:0], o_stat_lit_bytes[31:0].
  - Counters are saturating and cleared by rst_n.
  - lit_bytes sums ll of accepted summaries.
- Undefined: the ports and logic are absent. Core behaviour is identical.

Test Plan:
- head_ptr=0; summary ptr=0, ll=3, ml=5, move_forward=8 -> next cycle head_ptr=8, o_head_update=1; o_seq_valid=1 with ll=3, ml=5 one cycle later.
- Summary with ptr=4 while head_ptr=8 -> dropped: no push, no head change.
- Accepted summary with move_to_next_job=1, overlap_len=6, eoj=1 -> head_ptr=6, o_job_advance=1, o_stall=1 until the eoj entry pops with i_seq_ready=1.
- i_seq_ready=0, 8 accepted pushes (DEPTH=8) -> o_stall=1 once free<=4; 9th push -> o_overflow=1, FIFO holds the first 8 in order.
- Full FIFO, simultaneous push and pop -> count stays 8, no overflow; popped order preserved.
- Eoj with delim=1 popped -> state returns to IDLE. rst_n asserted mid-stream -> all outputs return to reset values immediately.
